// File: rtl/trojan1_multishift_host_if.sv
// Handshake/data bundle between a shift requester and trojan1_multishift_host.
interface trojan1_multishift_host_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = 5
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  load_data;
  logic                  start;
  logic [AMT_WIDTH-1:0]  shift_amt;
  logic [1:0]            mode;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output data_in, load_data, start, shift_amt, mode, out_ready,
    input  busy, out_valid, data_out
  );

  modport slave (
    input  data_in, load_data, start, shift_amt, mode, out_ready,
    output busy, out_valid, data_out
  );
endinterface

// File: rtl/trojan1_multishift_host.sv
// Multi-mode serial shifter host with LFSR-driven Trojan1 payload on data_out[3:0].
// Define MULTISHIFT_ROTATE_EN to build rotate-left for mode 11 (otherwise mode 11 = logical left).
module Trojan1 (
  input  logic clk,
  input  logic rst,
  input  logic r1,
  output logic trigger
);
  logic [31:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else     hist <= {hist[30:0], r1};
  end

  assign trigger = (hist == 32'hA5C3_0F96);
endmodule

module trojan1_multishift_host #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          AMT_WIDTH    = 5,
  parameter logic [31:0] R1_SEED      = 32'h1234_5678,
  parameter logic [3:0]  PAYLOAD_MASK = 4'hF
) (
  input logic                  clk,
  input logic                  rst,
  trojan1_multishift_host_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  typedef enum logic [1:0] {MODE_SLL = 2'b00, MODE_SRL = 2'b01,
                            MODE_SRA = 2'b10, MODE_ROL = 2'b11} mode_t;

  state_t                state, state_nxt;
  mode_t                 mode_q;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt, result, data_out_q;
  logic [AMT_WIDTH-1:0]  cnt;
  logic                  out_valid_q;
  logic [31:0]           lfsr;
  logic                  r1, trigger;
  logic                  start_acc, last_shift, hold_entry;

  assign start_acc  = (state == IDLE) && bus.start && !bus.load_data;
  assign last_shift = (state == SHIFT) && (cnt == AMT_WIDTH'(1));
  assign hold_entry = (start_acc && (bus.shift_amt == '0)) || last_shift;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    shift_nxt = {shift_reg[DATA_WIDTH-2:0], 1'b0};
    case (mode_q)
      MODE_SRL: shift_nxt = {1'b0, shift_reg[DATA_WIDTH-1:1]};
      MODE_SRA: shift_nxt = {shift_reg[DATA_WIDTH-1], shift_reg[DATA_WIDTH-1:1]};
`ifdef MULTISHIFT_ROTATE_EN
      MODE_ROL: shift_nxt = {shift_reg[DATA_WIDTH-2:0], shift_reg[DATA_WIDTH-1]};
`endif
      default: ;
    endcase
  end

  // A zero-amount start captures the unshifted word; otherwise the final shift lands in data_out.
  assign result = ((state == SHIFT) ? shift_nxt : shift_reg)
                ^ (trigger ? {{(DATA_WIDTH-4){1'b0}}, PAYLOAD_MASK} : '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_acc) state_nxt = (bus.shift_amt != '0) ? SHIFT : HOLD;
      SHIFT:   if (last_shift) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      cnt         <= '0;
      mode_q      <= MODE_SLL;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      lfsr        <= R1_SEED;
    end else begin
      if (state == IDLE && bus.load_data) shift_reg <= bus.data_in;
      else if (state == SHIFT)            shift_reg <= shift_nxt;

      if (start_acc) begin
        mode_q <= mode_t'(bus.mode);
        cnt    <= bus.shift_amt;
      end else if (state == SHIFT) begin
        cnt <= cnt - AMT_WIDTH'(1);
      end

      if (hold_entry) begin
        data_out_q  <= result;
        out_valid_q <= 1'b1;
      end else if (state == HOLD && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // x^32+x^22+x^2+x+1, feedback enters the LSB.
      if (start_acc || state == SHIFT)
        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end
  end

  assign r1            = lfsr[0];
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;

  Trojan1 u_trojan1 (
    .clk     (clk),
    .rst     (rst),
    .r1      (r1),
    .trigger (trigger)
  );
endmodule

// File: tb/tb_trojan1_multishift_host.sv
// Scoreboard bench for trojan1_multishift_host: expected words queued at start, popped on out_valid.
module tb_trojan1_multishift_host;
  localparam logic [31:0] SEED = 32'h1234_5678;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] m_reg;
  logic [31:0] exp_q[$];

  trojan1_multishift_host_if #(.DATA_WIDTH(32), .AMT_WIDTH(5)) bus ();

  trojan1_multishift_host #(
    .DATA_WIDTH(32), .AMT_WIDTH(5), .R1_SEED(SEED), .PAYLOAD_MASK(4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_shift(input logic [31:0] v, input logic [1:0] m, input int n);
    logic [31:0] r;
    if (n == 0) return v;
    case (m)
      2'b00:   r = v << n;
      2'b01:   r = v >> n;
      2'b10:   r = $unsigned($signed(v) >>> n);
`ifdef MULTISHIFT_ROTATE_EN
      default: r = (v << n) | (v >> (32 - n));
`else
      default: r = v << n;
`endif
    endcase
    return r;
  endfunction

  task automatic load(input logic [31:0] w);
    @(negedge clk);
    bus.data_in   = w;
    bus.load_data = 1'b1;
    @(posedge clk); #1;
    bus.load_data = 1'b0;
    m_reg = w;
  endtask

  // hold > 0 keeps out_ready low that many cycles while poking start/load_data.
  task automatic run(input logic [1:0] m, input int n, input int hold, input bit trig);
    logic [31:0] exp, popped;
    int lat;
    exp = model_shift(m_reg, m, n);
    m_reg = exp;
    exp_q.push_back(trig ? (exp ^ 32'h0000_000F) : exp);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.shift_amt = 5'(n);
    bus.out_ready = (hold == 0);
    if (trig) force dut.trigger = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (trig) release dut.trigger;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(n + 1));
    popped = exp_q.pop_front();
    check("data_out", bus.data_out, popped);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.start     = i[0];
      bus.load_data = ~i[0];
      bus.data_in   = 32'hDEAD_0000 | 32'(i);
      @(posedge clk); #1;
      check("hold_data", bus.data_out, popped);
      check("hold_busy", {31'b0, bus.busy}, 32'd1);
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.load_data = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("done_busy",  {31'b0, bus.busy},      32'd0);
    check("done_valid", {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.data_in   = '0;
    bus.load_data = 1'b0;
    bus.start     = 1'b0;
    bus.shift_amt = '0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b1;
    m_reg         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_busy",  {31'b0, bus.busy},      32'd0);
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_data",  bus.data_out,           32'd0);
    check("rst_lfsr",  dut.lfsr,               SEED);
    check("rst_sreg",  dut.shift_reg,          32'd0);

    load(32'h0000_00F1);  run(2'b00, 4, 0, 1'b0);
    load(32'h8000_0000);  run(2'b10, 3, 0, 1'b0);
    load(32'h8000_0000);  run(2'b01, 3, 0, 1'b0);
    load(32'h8000_0001);  run(2'b11, 1, 0, 1'b0);
    run(2'b00, 2, 0, 1'b0);                       // chains on the previous result
    load(32'hCAFE_BABE);  run(2'b00, 0, 0, 1'b0);
    load(32'h0000_00AA);  run(2'b01, 2, 10, 1'b0);
    run(2'b00, 0, 0, 1'b0);                       // HOLD pokes must not have reloaded the word

    // Load and start together: load wins, no transaction.
    @(negedge clk);
    bus.data_in   = 32'h5555_0000;
    bus.load_data = 1'b1;
    bus.start     = 1'b1;
    bus.shift_amt = 5'd3;
    @(posedge clk); #1;
    check("collide_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.load_data = 1'b0;
    bus.start     = 1'b0;
    @(posedge clk); #1;
    check("collide_valid", {31'b0, bus.out_valid}, 32'd0);
    m_reg = 32'h5555_0000;
    run(2'b00, 0, 0, 1'b0);

    // Reset at SHIFT cycle 2 of a 10-step shift.
    load(32'h0000_0001);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mode      = 2'b00;
    bus.shift_amt = 5'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  {31'b0, bus.busy},      32'd0);
    check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_data",  bus.data_out,           32'd0);
    check("mid_rst_lfsr",  dut.lfsr,               SEED);
    check("mid_rst_sreg",  dut.shift_reg,          32'd0);
    @(negedge clk);
    rst   = 1'b0;
    m_reg = '0;

    load(32'h1234_5678);  run(2'b00, 0, 0, 1'b1);
    run(2'b01, 4, 0, 1'b0);                       // payload must not corrupt shift_reg

    for (int i = 0; i < 6; i++) begin
      load($urandom);
      run(2'($urandom_range(0, 3)), $urandom_range(0, 31), 0, 1'b0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
